bram_lsu_port: RTL and testbench

- Load/store front-end sitting directly upstream of the single-port 32-bit block RAM in the embedded RV32I core.
- Accepts byte-addressed LB/LBU/LH/LHU/LW/SB/SH/SW requests from the core with a ready/ack handshake.
- Drives RAM en/we/addr/di and consumes RAM do.
- The RAM has no byte enables, so SB/SH are done as read-modify-write; loads are lane-aligned and sign/zero-extended.

---
 rtl/bram_lsu_pkg.sv | 18 +
 rtl/bram_lane_align.sv | 46 ++++
 rtl/bram_lsu_port.sv | 138 +++++++++++++
 tb/tb_bram_lsu_port.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/bram_lsu_pkg.sv
// Shared encodings for the block-RAM load/store port.
// Size codes, FSM states and lane width.
package bram_lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_X = 2'b11;

    localparam int LANE_W = 8;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        LD_WAIT  = 2'b01,
        ST_MERGE = 2'b10
    } state_t;

endpackage

// File: rtl/bram_lane_align.sv
// Lane extraction/extension for loads and lane merge for SB/SH.
// Purely combinational; shared by the load and merge paths.
module bram_lane_align
    import bram_lsu_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    output logic [31:0] ldata,
    output logic [31:0] mdata
);

    logic [31:0] lane;
    logic [15:0] half;
    logic        sb;
    logic        sh;

    assign lane = word >> {offset, 3'b000};
    assign half = offset[1] ? word[31:16] : word[15:0];
    assign sb   = ~is_unsigned & lane[7];
    assign sh   = ~is_unsigned & half[15];

    always_comb begin
        ldata = word;
        mdata = wdata;
        unique case (1'b1)
            (size == SZ_B): begin
                ldata = {{24{sb}}, lane[7:0]};
                mdata = word;
                mdata[{offset, 3'b000} +: LANE_W] = wdata[7:0];
            end
            (size == SZ_H): begin
                ldata = {{16{sh}}, half};
                mdata = word;
                mdata[{offset[1], 4'b0000} +: 2*LANE_W] = wdata[15:0];
            end
            default: begin
                ldata = word;
                mdata = wdata;
            end
        endcase
    end

endmodule

// File: rtl/bram_lsu_port.sv
// Load/store front-end for a single-port 32-bit block RAM.
// SB/SH use read-modify-write since the RAM has no byte enables.
module bram_lsu_port
    import bram_lsu_pkg::*;
#(
    parameter int DEPTH     = 256,
    parameter int DEPTH_LOG = 8
) (
    input  logic                 clk,
    input  logic                 resetb,
    input  logic                 req,
    input  logic                 req_we,
    input  logic [31:0]          req_addr,
    input  logic [1:0]           req_size,
    input  logic                 req_unsigned,
    input  logic [31:0]          req_wdata,
    output logic                 ready,
    output logic                 ack,
    output logic                 err,
    output logic [31:0]          rdata,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [DEPTH_LOG-1:0] mem_addr,
    output logic [31:0]          mem_di,
    input  logic [31:0]          mem_do
);

    state_t               state;
    state_t               state_d;
    logic [1:0]           off_q;
    logic [1:0]           size_q;
    logic                 uns_q;
    logic [15:0]          wdata_q;
    logic [DEPTH_LOG-1:0] addr_q;

    logic        accept;
    logic        mis;
    logic        go;
    logic        is_sw;
    logic        en_c;
    logic        we_c;
    logic        ack_d;
    logic        err_d;
    logic [31:0] ldata;
    logic [31:0] mdata;
    logic        unused_ok;

    assign unused_ok = ^{req_addr[31:DEPTH_LOG+2], DEPTH[0]};

    assign accept = (state == IDLE) & req;
    assign mis    = ((req_size == SZ_H) & req_addr[0])
                  | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
                  | (req_size == SZ_X);
    assign go     = accept & ~mis;
    assign is_sw  = req_we & (req_size == SZ_W);

    bram_lane_align u_align (
        .word        (mem_do),
        .offset      (off_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .wdata       ({16'h0000, wdata_q}),
        .ldata       (ldata),
        .mdata       (mdata)
    );

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) state <= IDLE;
        else         state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (1'b1)
            (state == IDLE): begin
                if (go & ~req_we)     state_d = LD_WAIT;
                else if (go & ~is_sw) state_d = ST_MERGE;
                else                  state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        en_c     = 1'b0;
        we_c     = 1'b0;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        mem_addr = addr_q;
        mem_di   = mdata;
        unique case (1'b1)
            (state == IDLE): begin
                en_c     = go;
                we_c     = go & is_sw;
                ack_d    = accept & (mis | is_sw);
                err_d    = accept & mis;
                mem_addr = req_addr[DEPTH_LOG+1:2];
                mem_di   = req_wdata;
            end
            (state == ST_MERGE): begin
                en_c  = 1'b1;
                we_c  = 1'b1;
                ack_d = 1'b1;
            end
            default: ack_d = 1'b1;
        endcase
    end

    // Gate RAM strobes with reset so an abandoned RMW never writes.
    assign mem_en = en_c & resetb;
    assign mem_we = we_c & resetb;
    assign ready  = (state == IDLE) & resetb;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            ack     <= 1'b0;
            err     <= 1'b0;
            rdata   <= 32'h0;
            off_q   <= 2'b00;
            size_q  <= SZ_B;
            uns_q   <= 1'b0;
            wdata_q <= 16'h0;
            addr_q  <= '0;
        end else begin
            ack <= ack_d;
            err <= err_d;
            if (state == LD_WAIT) rdata <= ldata;
            if (accept) begin
                off_q   <= req_addr[1:0];
                size_q  <= req_size;
                uns_q   <= req_unsigned;
                wdata_q <= req_wdata[15:0];
                addr_q  <= req_addr[DEPTH_LOG+1:2];
            end
        end
    end

endmodule

// File: tb/tb_bram_lsu_port.sv
// Directed bench for bram_lsu_port with a behavioural write-first RAM.
// Inputs change on the falling edge; outputs are checked there too.
module tb_bram_lsu_port;

    logic        clk = 1'b0;
    logic        resetb;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        ready;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_addr;
    logic [31:0] mem_di;
    logic [31:0] mem_do;

    logic [31:0] ram [256];
    int npass = 0;
    int ntot  = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_di;
                mem_do        <= mem_di;
            end else begin
                mem_do <= ram[mem_addr];
            end
        end
    end

    bram_lsu_port #(.DEPTH(256), .DEPTH_LOG(8)) dut (
        .clk          (clk),
        .resetb       (resetb),
        .req          (req),
        .req_we       (req_we),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .ready        (ready),
        .ack          (ack),
        .err          (err),
        .rdata        (rdata),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_di       (mem_di),
        .mem_do       (mem_do)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic set_req(input logic we, input logic [31:0] a,
                           input logic [1:0] sz, input logic u,
                           input logic [31:0] wd);
        req          = 1'b1;
        req_we       = we;
        req_addr     = a;
        req_size     = sz;
        req_unsigned = u;
        req_wdata    = wd;
    endtask

    task automatic do_load(input string tag, input logic [31:0] a,
                           input logic [1:0] sz, input logic u,
                           input logic [31:0] exp);
        @(negedge clk);
        set_req(1'b0, a, sz, u, 32'h0);
        #1;
        chk({tag, "_en"}, {31'b0, mem_en}, 32'd1);
        chk({tag, "_we"}, {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        chk({tag, "_wait_ack"}, {31'b0, ack}, 32'd0);
        chk({tag, "_wait_rdy"}, {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_rdata"}, rdata, exp);
    endtask

    task automatic do_bad(input string tag, input logic [31:0] a,
                          input logic [1:0] sz, input logic [31:0] rd);
        @(negedge clk);
        set_req(1'b0, a, sz, 1'b0, 32'h0);
        #1;
        chk({tag, "_en"}, {31'b0, mem_en}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        chk({tag, "_ack"}, {31'b0, ack}, 32'd1);
        chk({tag, "_err"}, {31'b0, err}, 32'd1);
        chk({tag, "_rdata"}, rdata, rd);
        #1;
        chk({tag, "_en2"}, {31'b0, mem_en}, 32'd0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 32'h0;
        mem_do = 32'h0;
        resetb = 1'b0;
        set_req(1'b0, 32'h0, 2'b00, 1'b0, 32'h0);
        req = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_en", {31'b0, mem_en}, 32'd0);
        resetb = 1'b1;
        #1;
        chk("rel_ready", {31'b0, ready}, 32'd1);

        // SW 0x10
        @(negedge clk);
        set_req(1'b1, 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);
        #1;
        chk("sw_en", {31'b0, mem_en}, 32'd1);
        chk("sw_we", {31'b0, mem_we}, 32'd1);
        chk("sw_addr", {24'b0, mem_addr}, 32'd4);
        chk("sw_di", mem_di, 32'hDEADBEEF);
        @(negedge clk);
        req = 1'b0;
        chk("sw_ack", {31'b0, ack}, 32'd1);
        chk("sw_err", {31'b0, err}, 32'd0);
        chk("sw_rdy", {31'b0, ready}, 32'd1);

        do_load("lw1", 32'h10, 2'b10, 1'b0, 32'hDEADBEEF);

        // SB 0x11 <- 0x55 as read then merge-write
        @(negedge clk);
        set_req(1'b1, 32'h11, 2'b00, 1'b0, 32'h00000055);
        #1;
        chk("sb_rd_en", {31'b0, mem_en}, 32'd1);
        chk("sb_rd_we", {31'b0, mem_we}, 32'd0);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("sb_wr_en", {31'b0, mem_en}, 32'd1);
        chk("sb_wr_we", {31'b0, mem_we}, 32'd1);
        chk("sb_wr_addr", {24'b0, mem_addr}, 32'd4);
        chk("sb_wr_di", mem_di, 32'hDEAD55EF);
        chk("sb_no_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("sb_ack", {31'b0, ack}, 32'd1);
        chk("sb_rhold", rdata, 32'hDEADBEEF);

        do_load("lw2", 32'h10, 2'b10, 1'b0, 32'hDEAD55EF);
        do_load("lb", 32'h13, 2'b00, 1'b0, 32'hFFFFFFDE);
        do_load("lbu", 32'h13, 2'b00, 1'b1, 32'h000000DE);
        do_load("lh", 32'h12, 2'b01, 1'b0, 32'hFFFFDEAD);
        do_load("lhu", 32'h10, 2'b01, 1'b1, 32'h000055EF);

        do_bad("bad_lh", 32'h11, 2'b01, 32'h000055EF);
        do_bad("bad_lw", 32'h12, 2'b10, 32'h000055EF);
        do_bad("bad_sz", 32'h10, 2'b11, 32'h000055EF);

        // req held high: SW 0x400 (word 0), LW 0x0, SW 0x24, LW 0x24
        @(negedge clk);
        set_req(1'b1, 32'h400, 2'b10, 1'b0, 32'h11111111);
        #1;
        chk("b2b_sw0_addr", {24'b0, mem_addr}, 32'd0);
        chk("b2b_sw0_we", {31'b0, mem_we}, 32'd1);
        @(negedge clk);
        set_req(1'b0, 32'h0, 2'b10, 1'b0, 32'h0);
        #1;
        chk("b2b_sw0_ack", {31'b0, ack}, 32'd1);
        chk("b2b_lw0_en", {31'b0, mem_en}, 32'd1);
        chk("b2b_lw0_rdy", {31'b0, ready}, 32'd1);
        @(negedge clk);
        set_req(1'b1, 32'h24, 2'b10, 1'b0, 32'h22222222);
        #1;
        chk("b2b_wait_rdy", {31'b0, ready}, 32'd0);
        chk("b2b_wait_en", {31'b0, mem_en}, 32'd0);
        chk("b2b_wait_ack", {31'b0, ack}, 32'd0);
        @(negedge clk);
        #1;
        chk("b2b_lw0_ack", {31'b0, ack}, 32'd1);
        chk("b2b_lw0_rd", rdata, 32'h11111111);
        chk("b2b_sw1_addr", {24'b0, mem_addr}, 32'd9);
        chk("b2b_sw1_we", {31'b0, mem_we}, 32'd1);
        @(negedge clk);
        set_req(1'b0, 32'h24, 2'b10, 1'b0, 32'h0);
        #1;
        chk("b2b_sw1_ack", {31'b0, ack}, 32'd1);
        chk("b2b_lw1_en", {31'b0, mem_en}, 32'd1);
        @(negedge clk);
        req = 1'b0;
        chk("b2b_lw1_wait", {31'b0, ack}, 32'd0);
        @(negedge clk);
        chk("b2b_lw1_ack", {31'b0, ack}, 32'd1);
        chk("b2b_lw1_rd", rdata, 32'h22222222);
        @(negedge clk);
        chk("b2b_no_dup", {31'b0, ack}, 32'd0);

        // Reset during ST_MERGE of SH 0x10
        @(negedge clk);
        set_req(1'b1, 32'h10, 2'b01, 1'b0, 32'h0000ABCD);
        @(negedge clk);
        req = 1'b0;
        #1;
        chk("rmw_merge_we", {31'b0, mem_we}, 32'd1);
        resetb = 1'b0;
        #1;
        chk("rmw_rst_en", {31'b0, mem_en}, 32'd0);
        chk("rmw_rst_we", {31'b0, mem_we}, 32'd0);
        chk("rmw_rst_rdy", {31'b0, ready}, 32'd0);
        @(negedge clk);
        chk("rmw_rst_ack", {31'b0, ack}, 32'd0);
        chk("rmw_rst_err", {31'b0, err}, 32'd0);
        chk("rmw_rst_rdata", rdata, 32'h0);
        resetb = 1'b1;
        #1;
        chk("rmw_rel_rdy", {31'b0, ready}, 32'd1);
        @(negedge clk);
        chk("rmw_rel_ack", {31'b0, ack}, 32'd0);
        chk("rmw_ram", ram[4], 32'hDEAD55EF);
        do_load("rmw_lw", 32'h10, 2'b10, 1'b0, 32'hDEAD55EF);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
